// File: rtl/rx_tap_calibrator.sv
// rx_tap_calibrator: sweeps delay-tap codes, accumulates symbol magnitude per tap, locks onto the best; optional auto-recalibration via RXCAL_AUTO_RESTART_EN
module rx_tap_calibrator #(
  parameter int NUM_TAPS    = 5,
  parameter int LOG2_N      = 8,
  parameter int SETTLE_SYMS = 4,
  parameter int RECAL_SYMS  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sym_clk,
  input  logic                start,
  input  logic signed [17:0]  sym_in,
  output logic [2:0]          tap_sel,
  output logic                busy,
  output logic                done,
  output logic [16+LOG2_N:0]  best_metric
);
  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, COMPARE, COMMIT} state_t;
  localparam int AW = 17 + LOG2_N;
  localparam int ACC_N = 1 << LOG2_N;
  localparam int M1 = SETTLE_SYMS > ACC_N ? SETTLE_SYMS : ACC_N;
  localparam int CNT_MAX = M1 > RECAL_SYMS ? M1 : RECAL_SYMS;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_SYMS - 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(ACC_N - 1);
  localparam logic [2:0] LAST_CAND = 3'(NUM_TAPS - 1);
  state_t r_state, w_next;
  logic [2:0] r_cand, r_best_tap;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [16:0] w_mag;
  logic w_go, w_last_set, w_last_acc, w_take, w_last_cand;
`ifdef RXCAL_AUTO_RESTART_EN
  localparam logic [CW-1:0] RECAL_LAST = CW'(RECAL_SYMS - 1);
  logic r_swept;
  assign w_go = start || (r_swept && sym_clk && r_cnt == RECAL_LAST);
`else
  assign w_go = start;
`endif
  assign w_mag = sym_in[17] ? (sym_in[16:0] == 17'd0 ? 17'h1FFFF : ~sym_in[16:0] + 17'd1) : sym_in[16:0];
  assign w_last_set = sym_clk && r_cnt == SET_LAST;
  assign w_last_acc = sym_clk && r_cnt == ACC_LAST;
  assign w_take = r_cand == 3'd0 || r_acc > best_metric;
  assign w_last_cand = r_cand == LAST_CAND;
  // next-state decode; sym_clk only advances the sweep in SETTLE and ACCUM
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? SETTLE : IDLE;
      SETTLE:  w_next = w_last_set ? ACCUM : SETTLE;
      ACCUM:   w_next = w_last_acc ? COMPARE : ACCUM;
      COMPARE: w_next = w_last_cand ? COMMIT : SETTLE;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state register, registered outputs and datapath; the shared counter also times idle in auto-restart builds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      tap_sel     <= 3'd4;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_metric <= '0;
      r_cand      <= 3'd0;
      r_best_tap  <= 3'd0;
      r_acc       <= '0;
      r_cnt       <= '0;
`ifdef RXCAL_AUTO_RESTART_EN
      r_swept     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      busy    <= w_next == SETTLE || w_next == ACCUM || w_next == COMPARE;
      done    <= w_next == COMMIT;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_cand      <= 3'd0;
            tap_sel     <= 3'd0;
            r_acc       <= '0;
            best_metric <= '0;
            r_best_tap  <= 3'd0;
            r_cnt       <= '0;
          end
`ifdef RXCAL_AUTO_RESTART_EN
          else if (r_swept && sym_clk) r_cnt <= r_cnt + 1'b1;
`endif
        end
        SETTLE: if (sym_clk) r_cnt <= w_last_set ? '0 : r_cnt + 1'b1;
        ACCUM: begin
          if (sym_clk) begin
            r_acc <= r_acc + AW'(w_mag);
            r_cnt <= w_last_acc ? '0 : r_cnt + 1'b1;
          end
        end
        COMPARE: begin
          if (w_take) begin
            best_metric <= r_acc;
            r_best_tap  <= r_cand;
          end
          if (w_last_cand) tap_sel <= w_take ? r_cand : r_best_tap;
          else begin
            r_cand  <= r_cand + 3'd1;
            tap_sel <= r_cand + 3'd1;
            r_acc   <= '0;
          end
        end
        COMMIT: begin
`ifdef RXCAL_AUTO_RESTART_EN
          r_swept <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
